// File: rtl/apb_clint_timer_pkg.sv
// Shared definitions for the CLINT machine-timer block: register offsets, APB FSM states, byte-merge helper.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package apb_clint_timer_pkg;

    localparam logic [15:0] CLINT_MSIP_OFS     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_OFS = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_OFS    = 16'hBFF8;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_ACCESS = 2'd1,
        APB_RESP   = 2'd2
    } apb_state_e;

    // Replace only the bytes selected by strb; the rest keep their old value.
    function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// Prescaler for mtime: counts 0..TICK_DIV-1 and pulses tick on the wrap cycle.
// Latency: tick is combinational from the counter; TICK_DIV=1 gives tick every cycle.
// Backpressure: none, free-running.
module clint_tick_gen #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_MAX);

    // Prescale counter, restarts from 0 on every tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/apb_clint_timer.sv
// APB completer for mtime/mtimecmp (and msip when CLINT_MSIP_EN is defined); drives mtime and mtimer_int to the core.
// Latency: one wait state; pready rises 2 cycles after the setup cycle; writes commit on the edge leaving RESP.
// Backpressure: none beyond the fixed wait state; psel dropping during ACCESS aborts the transfer without effect.
module apb_clint_timer #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    output logic              pready,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              pwrite,
    input  logic [31:0]       pwdata,
    input  logic [3:0]        pwstrb,
    output logic [31:0]       prdata,
    output logic              pslverr,
    output logic [63:0]       mtime,
    output logic              mtimer_int
`ifdef CLINT_MSIP_EN
   ,output logic              msip_int
`endif
);
    import apb_clint_timer_pkg::*;

    localparam logic [ADDR_W-1:0] A_MSIP   = ADDR_W'(CLINT_MSIP_OFS);
    localparam logic [ADDR_W-1:0] A_CMP_LO = ADDR_W'(CLINT_MTIMECMP_OFS);
    localparam logic [ADDR_W-1:0] A_CMP_HI = ADDR_W'(CLINT_MTIMECMP_OFS + 16'd4);
    localparam logic [ADDR_W-1:0] A_MT_LO  = ADDR_W'(CLINT_MTIME_OFS);
    localparam logic [ADDR_W-1:0] A_MT_HI  = ADDR_W'(CLINT_MTIME_OFS + 16'd4);

    apb_state_e        state, state_nxt;
    logic              tick;
    logic [63:0]       mtimecmp;
    logic              dec_err;
    logic [31:0]       dec_rdata;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_strb;
    logic              acc_write;
    logic              acc_err;
    logic              commit;
`ifdef CLINT_MSIP_EN
    logic              msip;
    assign msip_int = msip;
`endif

    clint_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // A write lands only when a successful transfer leaves RESP.
    assign commit = (state == APB_RESP) && acc_write && !acc_err;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= APB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: setup phase enters ACCESS, ACCESS always moves on unless psel drops.
    always_comb begin
        state_nxt = state;
        case (state)
            APB_IDLE:   state_nxt = (psel && !penable) ? APB_ACCESS : APB_IDLE;
            APB_ACCESS: state_nxt = psel ? APB_RESP : APB_IDLE;
            APB_RESP:   state_nxt = (psel && !penable) ? APB_ACCESS : APB_IDLE;
            default:    state_nxt = APB_IDLE;
        endcase
    end

    // FSM outputs: ready is asserted only for the single RESP cycle.
    always_comb begin
        pready = 1'b0;
        if (state == APB_RESP) begin
            pready = 1'b1;
        end
    end

    // Address decode and read mux against the live bus address during ACCESS.
    always_comb begin
        dec_err   = 1'b0;
        dec_rdata = '0;
        if (paddr[1:0] != 2'b00) begin
            dec_err = 1'b1;
        end else if (paddr == A_CMP_LO) begin
            dec_rdata = mtimecmp[31:0];
        end else if (paddr == A_CMP_HI) begin
            dec_rdata = mtimecmp[63:32];
        end else if (paddr == A_MT_LO) begin
            dec_rdata = mtime[31:0];
        end else if (paddr == A_MT_HI) begin
            dec_rdata = mtime[63:32];
`ifdef CLINT_MSIP_EN
        end else if (paddr == A_MSIP) begin
            dec_rdata = {31'b0, msip};
`endif
        end else begin
            dec_err = 1'b1;
        end
    end

    // Capture the transfer in ACCESS so the commit does not depend on the bus after RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_addr  <= '0;
            acc_wdata <= '0;
            acc_strb  <= '0;
            acc_write <= 1'b0;
            acc_err   <= 1'b0;
        end else if (state == APB_ACCESS && psel) begin
            acc_addr  <= paddr;
            acc_wdata <= pwdata;
            acc_strb  <= pwstrb;
            acc_write <= pwrite;
            acc_err   <= dec_err;
        end
    end

    // Registered response: valid only during RESP, zero everywhere else and on error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prdata  <= '0;
            pslverr <= 1'b0;
        end else if (state == APB_ACCESS && psel) begin
            prdata  <= dec_err ? 32'h0 : dec_rdata;
            pslverr <= dec_err;
        end else begin
            prdata  <= '0;
            pslverr <= 1'b0;
        end
    end

    // mtime: a write to either half wins over the tick, so that cycle's increment is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime <= '0;
        end else if (commit && acc_addr == A_MT_LO) begin
            mtime[31:0] <= merge_strb(mtime[31:0], acc_wdata, acc_strb);
        end else if (commit && acc_addr == A_MT_HI) begin
            mtime[63:32] <= merge_strb(mtime[63:32], acc_wdata, acc_strb);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // mtimecmp halves, byte-strobed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtimecmp <= '1;
        end else if (commit && acc_addr == A_CMP_LO) begin
            mtimecmp[31:0] <= merge_strb(mtimecmp[31:0], acc_wdata, acc_strb);
        end else if (commit && acc_addr == A_CMP_HI) begin
            mtimecmp[63:32] <= merge_strb(mtimecmp[63:32], acc_wdata, acc_strb);
        end
    end

    // Timer interrupt follows the unsigned compare one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtimer_int <= 1'b0;
        end else begin
            mtimer_int <= (mtime >= mtimecmp);
        end
    end

`ifdef CLINT_MSIP_EN
    // Software interrupt bit, only byte 0 strobe matters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msip <= 1'b0;
        end else if (commit && acc_addr == A_MSIP && acc_strb[0]) begin
            msip <= acc_wdata[0];
        end
    end
`endif

endmodule

// File: tb/tb_apb_clint_timer.sv
// Self-checking bench for apb_clint_timer (TICK_DIV=1): directed scenarios plus randomized APB traffic.
// Latency: expects pready 2 cycles after setup and write effects on the edge after RESP.
// Backpressure: exercises back-to-back transfers, idle gaps, aborts and mid-transfer reset.
module tb_apb_clint_timer;

    logic        clk;
    logic        rst;
    logic        psel, penable, pwrite;
    logic        pready, pslverr, mtimer_int;
    logic [15:0] paddr;
    logic [31:0] pwdata, prdata;
    logic [3:0]  pwstrb;
    logic [63:0] mtime;
`ifdef CLINT_MSIP_EN
    logic        msip_int;
`endif

    apb_clint_timer #(.ADDR_W(16), .TICK_DIV(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .psel       (psel),
        .penable    (penable),
        .pready     (pready),
        .paddr      (paddr),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .pwstrb     (pwstrb),
        .prdata     (prdata),
        .pslverr    (pslverr),
        .mtime      (mtime),
        .mtimer_int (mtimer_int)
`ifdef CLINT_MSIP_EN
       ,.msip_int   (msip_int)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: architectural registers only.
    logic [63:0] m_mtime, m_cmp;
    logic        m_int, m_msip;
    // Pending write that takes effect at the next rising edge.
    logic        mdl_wr = 1'b0;
    logic [15:0] mdl_addr = '0;
    logic [31:0] mdl_data = '0;
    logic [3:0]  mdl_strb = '0;

    function automatic logic [31:0] bytes_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic bit msip_present();
`ifdef CLINT_MSIP_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit is_err(input logic [15:0] a);
        case (a)
            16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC: return 1'b0;
            16'h0000: return !msip_present();
            default:  return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] exp_read(input logic [15:0] a);
        case (a)
            16'h4000: return m_cmp[31:0];
            16'h4004: return m_cmp[63:32];
            16'hBFF8: return m_mtime[31:0];
            16'hBFFC: return m_mtime[63:32];
            16'h0000: return {31'b0, m_msip};
            default:  return 32'h0;
        endcase
    endfunction

    // Behavioural model: every cycle mtime counts up unless software writes it.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mtime <= 64'd0;
            m_cmp   <= {64{1'b1}};
            m_int   <= 1'b0;
            m_msip  <= 1'b0;
        end else begin
            m_int <= (m_mtime >= m_cmp);
            if (mdl_wr && mdl_addr == 16'hBFF8)
                m_mtime <= {m_mtime[63:32], bytes_merge(m_mtime[31:0], mdl_data, mdl_strb)};
            else if (mdl_wr && mdl_addr == 16'hBFFC)
                m_mtime <= {bytes_merge(m_mtime[63:32], mdl_data, mdl_strb), m_mtime[31:0]};
            else
                m_mtime <= m_mtime + 64'd1;
            if (mdl_wr && mdl_addr == 16'h4000) m_cmp[31:0]  <= bytes_merge(m_cmp[31:0], mdl_data, mdl_strb);
            if (mdl_wr && mdl_addr == 16'h4004) m_cmp[63:32] <= bytes_merge(m_cmp[63:32], mdl_data, mdl_strb);
            if (mdl_wr && mdl_addr == 16'h0000 && mdl_strb[0] && msip_present()) m_msip <= mdl_data[0];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_timer(input string tag);
        check({tag, ".mtime"}, mtime, m_mtime);
        check({tag, ".mtimer_int"}, {63'b0, mtimer_int}, {63'b0, m_int});
    endtask

    task automatic step();
        @(negedge clk);
        mdl_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            check("idle.pready", {63'b0, pready}, 64'd0);
            check_timer("idle");
        end
    endtask

    // Full transfer starting at a negedge (setup cycle); returns at the RESP negedge.
    task automatic xfer(input logic [15:0] a, input logic wr, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd);
        logic        e_err;
        logic [31:0] e_rd;
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = d; pwstrb = s;
        step();
        penable = 1'b1;
        check("access.pready", {63'b0, pready}, 64'd0);
        e_err = is_err(a);
        e_rd  = e_err ? 32'h0 : exp_read(a);
        step();
        check("resp.pready", {63'b0, pready}, 64'd1);
        check("resp.pslverr", {63'b0, pslverr}, {63'b0, e_err});
        if (!wr || e_err) check("resp.prdata", {32'b0, prdata}, {32'b0, e_rd});
        check_timer("resp");
        rd = prdata;
        if (wr && !e_err) begin
            mdl_wr = 1'b1; mdl_addr = a; mdl_data = d; mdl_strb = s;
        end
    endtask

    // Setup phase followed by psel dropping in the access phase.
    task automatic abort_xfer(input logic [15:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = 1'b1; pwdata = d; pwstrb = 4'hF;
        step();
        psel = 1'b0; penable = 1'b0;
        step();
        check("abort.pready", {63'b0, pready}, 64'd0);
        step();
        check("abort.pready2", {63'b0, pready}, 64'd0);
        check_timer("abort");
    endtask

    logic [31:0] rd;
    logic [31:0] t_lo;
    logic [63:0] pre;
    logic [15:0] addr_tbl [6];
    bit          seen;
    bit          rdy_seen;

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pwstrb = '0;
        addr_tbl[0] = 16'h0000; addr_tbl[1] = 16'h4000; addr_tbl[2] = 16'h4004;
        addr_tbl[3] = 16'hBFF8; addr_tbl[4] = 16'hBFFC; addr_tbl[5] = 16'h1234;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst.pready", {63'b0, pready}, 64'd0);
        check("rst.prdata", {32'b0, prdata}, 64'd0);
        check("rst.pslverr", {63'b0, pslverr}, 64'd0);
        check("rst.mtime", mtime, 64'd0);
        check("rst.mtimer_int", {63'b0, mtimer_int}, 64'd0);
        rst = 1'b0;

        // Free running for 10 cycles
        rdy_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (pready) rdy_seen = 1'b1;
        end
        check("idle10.mtime", mtime, 64'd10);
        check("idle10.pready_seen", {63'b0, rdy_seen}, 64'd0);
        check_timer("idle10");

        // Compare match raises mtimer_int the cycle after mtime reaches mtimecmp
        t_lo = m_mtime[31:0] + 32'd30;
        xfer(16'h4000, 1'b1, t_lo, 4'hF, rd);
        xfer(16'h4004, 1'b1, 32'h0, 4'hF, rd);
        psel = 1'b0; penable = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            check_timer("cmp.watch");
            if (mtimer_int && !seen) begin
                seen = 1'b1;
                check("cmp.rise_at", mtime, {32'b0, t_lo} + 64'd1);
            end
        end
        check("cmp.rose", {63'b0, seen}, 64'd1);
        xfer(16'h4004, 1'b1, 32'h1, 4'hF, rd);
        idle(2);
        check("cmp.fall", {63'b0, mtimer_int}, 64'd0);

        // Reads: mapped, unmapped, misaligned, msip
        xfer(16'hBFF8, 1'b0, 32'h0, 4'h0, rd);
        xfer(16'h1234, 1'b0, 32'h0, 4'h0, rd);
        check("err.prdata", {32'b0, rd}, 64'd0);
        xfer(16'hBFF9, 1'b0, 32'h0, 4'h0, rd);
        xfer(16'h0000, 1'b0, 32'h0, 4'h0, rd);
        idle(1);

        // Wrap from all-ones to zero
        xfer(16'hBFFC, 1'b1, 32'hFFFF_FFFF, 4'hF, rd);
        xfer(16'hBFF8, 1'b1, 32'hFFFF_FFFF, 4'hF, rd);
        psel = 1'b0; penable = 1'b0;
        step();
        check("wrap.ones", mtime, {64{1'b1}});
        step();
        check("wrap.zero", mtime, 64'd0);
        check_timer("wrap");

        // Carry from low half into high half
        xfer(16'hBFFC, 1'b1, 32'h0, 4'hF, rd);
        xfer(16'hBFF8, 1'b1, 32'hFFFF_FFFF, 4'hF, rd);
        psel = 1'b0; penable = 1'b0;
        step();
        step();
        check("carry.hi", {32'b0, mtime[63:32]}, 64'd1);
        check("carry.lo", {32'b0, mtime[31:0]}, 64'd0);

        // Byte strobe write, then back-to-back readback
        idle(1);
        xfer(16'hBFF8, 1'b1, 32'h0000_AB00, 4'b0010, rd);
        pre = m_mtime;
        xfer(16'hBFF8, 1'b0, 32'h0, 4'h0, rd);
        check("strb.byte1", {32'b0, rd}, {32'b0, pre[31:16], 8'hAB, pre[7:0]});
        // Zero-strobe write is a no-op on data
        xfer(16'h4004, 1'b1, 32'hDEAD_BEEF, 4'b0000, rd);
        xfer(16'h4004, 1'b0, 32'h0, 4'h0, rd);
        check("strb.zero", {32'b0, rd}, 64'd1);
        idle(1);

`ifdef CLINT_MSIP_EN
        xfer(16'h0000, 1'b1, 32'h1, 4'h1, rd);
        idle(1);
        check("msip.set", {63'b0, msip_int}, 64'd1);
`endif

        // Abort leaves registers untouched
        abort_xfer(16'h4000, 32'h1234_5678);
        xfer(16'h4000, 1'b0, 32'h0, 4'h0, rd);
        idle(1);

        // Reset during ACCESS of a write
        psel = 1'b1; penable = 1'b0; paddr = 16'h4000; pwrite = 1'b1; pwdata = 32'h0; pwstrb = 4'hF;
        step();
        penable = 1'b1;
        #2 rst = 1'b1;
        step();
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        check("midrst.pready", {63'b0, pready}, 64'd0);
        check("midrst.mtime", mtime, 64'd0);
        check("midrst.mtimer_int", {63'b0, mtimer_int}, 64'd0);
`ifdef CLINT_MSIP_EN
        check("midrst.msip", {63'b0, msip_int}, 64'd0);
`endif
        idle(3);
        xfer(16'h4000, 1'b0, 32'h0, 4'h0, rd);
        check("midrst.cmp_lo", {32'b0, rd}, 64'h0000_0000_FFFF_FFFF);
        idle(1);

        // Randomized traffic against the model
        for (int k = 0; k < 150; k++) begin
            logic [15:0] a;
            int          sel;
            sel = int'($urandom_range(0, 6));
            if (sel == 6) a = 16'($urandom);
            else          a = addr_tbl[sel];
            if ($urandom_range(0, 9) == 0) begin
                abort_xfer(a, $urandom);
            end else begin
                xfer(a, 1'($urandom), $urandom, 4'($urandom), rd);
                idle(int'($urandom_range(0, 2)));
            end
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
